mlp_layer_engine: RTL and testbench
===================================

# mlp_layer_engine

Sequencer that drives the neuron memory's read and write ports to compute one fully connected layer. For each output neuron j it streams in_count input activations and matching weights, multiply-accumulates them, applies shift, optional ReLU and saturation, then writes the result back into neuron memory at out_base+j. It sits beside `neuron_mem` and a weight ROM/RAM under the top-level network controller, which launches one layer per start pulse.

## Interface
- ADDR_W, 12, neuron memory address width
- WADDR_W, 16, weight memory address width
- DATA_W, 16, signed activation/weight width
- ACC_W, 40, signed accumulator width
- FRAC, 0, arithmetic right shift applied to the accumulator before ReLU/saturation
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch layer; sampled only in IDLE
- relu_en  in  1  apply ReLU to results
- in_base, out_base  in  ADDR_W  first input / first output neuron address
- in_count, out_count  in  ADDR_W  number of input / output neurons
- w_base  in  WADDR_W  address of weight row 0, element 0
- neuron_val  in  DATA_W  signed read data from neuron memory, 1-cycle latency
- weight  in  DATA_W  signed read data from weight memory, 1-cycle latency
- input_addr  out  ADDR_W  neuron memory read address (registered)
- weight_addr  out  WADDR_W  weight memory read address (registered)
- output_addr  out  ADDR_W  neuron memory write address (registered)
- data  out  DATA_W  neuron memory write data (registered)
- write_enable  out  1  one-cycle write strobe
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse at layer completion

## Operation
- Reset: state IDLE; every output 0 (addresses, data, write_enable, busy, done); accumulator 0. Reset mid-layer aborts it: no further writes and no done pulse.
- All configuration inputs are latched on the start-accept edge. Later changes are ignored until the next start. start while busy is ignored.
- States: IDLE -> READ -> DRAIN -> WRITE -> (READ | DRAIN for next row | DONE) -> IDLE.
- READ: one cycle per element i=0..in_count-1. Drives input_addr=in_base+i and weight_addr=w_base+j*in_count+i. In the same cycle, the product for element i-1 (returned data) is accumulated.
- DRAIN: accumulates the last product; no new address.
- WRITE: write_enable=1, output_addr=out_base+j, data=sat(relu(acc>>>FRAC)). Accumulator clears for the next row. j increments.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic: full DATA_W x DATA_W signed product sign-extended to ACC_W; accumulator wraps modulo 2^ACC_W; arithmetic shift; ReLU maps negatives to 0; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Address arithmetic wraps modulo 2^ADDR_W / 2^WADDR_W.
- in_count=0: rows skip READ (DRAIN then WRITE) and write 0.
- out_count=0: start -> DONE directly, no writes.
- The input and output regions must not overlap. This is a caller precondition and is not checked.

## Timing
- Start accepted at edge E0. busy=1 from the next cycle through the last WRITE cycle.
- Each row takes in_count+2 cycles. busy lasts out_count*(in_count+2) cycles. done is high in the following cycle with busy=0.
- Memory read latency is 1: data for the address driven in cycle k is consumed at the end of cycle k+1.
- Writes for row j complete before row j+1 issues its first read.
- write_enable is never high for two consecutive cycles when in_count>=1.

## Structure
- Shared package `mlp_pkg`: DATA_W/ADDR_W/ACC_W constants, the state enum, and the saturate function.
- Sub-module `neuron_mac`: clear/accumulate enables, signed multiply-accumulate, shift/ReLU/saturate output. The FSM and address counters stay in the top.

## Test plan
- Neuron memory holds 7,3,-8,5 at addresses 0..3. in_base=0, in_count=4, out_base=16, out_count=2, w_base=0, weights 1,2,1,1, 1,1,2,0, relu_en=0 -> writes 10@16 then -6@17. busy lasts 12 cycles, then done pulses once.
- Same setup with relu_en=1 -> writes 10@16, 0@17.
- Row weights 32767,32767,0,0 -> 32767 (saturated). Row -32768,-32768,0,0 with relu_en=0 -> -32768.
- in_count=0, out_count=3 -> three writes of 0 at out_base..out_base+2, each 2 cycles apart. out_count=0 -> done one cycle after busy with no writes.
- Reset asserted mid-row 1 -> all outputs 0 next cycle, no write to out_base+1, no done. A new start then runs the full layer correctly.
- start pulsed while busy, and configuration changed mid-layer -> results identical to the undisturbed run.

Source files
------------

// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared widths, sequencer states and saturation helper for the MLP layer engine
package mlp_pkg;

    localparam int MLP_ADDR_W  = 12;
    localparam int MLP_WADDR_W = 16;
    localparam int MLP_DATA_W  = 16;
    localparam int MLP_ACC_W   = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Largest / smallest DATA_W-bit signed values, held at accumulator width for comparison.
    localparam logic signed [MLP_ACC_W-1:0] SAT_MAX =
        {{(MLP_ACC_W-MLP_DATA_W+1){1'b0}}, {(MLP_DATA_W-1){1'b1}}};
    localparam logic signed [MLP_ACC_W-1:0] SAT_MIN =
        {{(MLP_ACC_W-MLP_DATA_W+1){1'b1}}, {(MLP_DATA_W-1){1'b0}}};

    // Clamp a wide signed value into the signed activation range.
    function automatic logic signed [MLP_DATA_W-1:0] saturate(input logic signed [MLP_ACC_W-1:0] v);
        logic signed [MLP_DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[MLP_DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[MLP_DATA_W-1:0];
        end else begin
            r = v[MLP_DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - signed multiply-accumulate with shift, optional ReLU and saturated output
module neuron_mac
    import mlp_pkg::*;
#(
    parameter int DATA_W = MLP_DATA_W,
    parameter int ACC_W  = MLP_ACC_W,
    parameter int FRAC   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic                     relu_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result
);

    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    product_ext;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [ACC_W-1:0]    rectified;

    assign product     = a * b;
    assign product_ext = {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};

    // Next accumulator value; the output is taken from it so the last product
    // is already included in the cycle it arrives.
    always_comb begin
        acc_next = acc;
        if (clear) begin
            acc_next = '0;
        end else if (acc_en) begin
            acc_next = acc + product_ext;
        end
    end

    // Shift, rectify and clamp the running sum into an activation.
    always_comb begin
        shifted   = acc_next >>> FRAC;
        rectified = shifted;
        if (relu_en && shifted[ACC_W-1]) begin
            rectified = '0;
        end
        result = saturate(rectified);
    end

    // Accumulator register, wraps modulo 2^ACC_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/mlp_layer_engine.sv
// rtl/mlp_layer_engine.sv - sequences neuron/weight memory reads and result writes for one dense layer
module mlp_layer_engine
    import mlp_pkg::*;
#(
    parameter int ADDR_W  = MLP_ADDR_W,
    parameter int WADDR_W = MLP_WADDR_W,
    parameter int DATA_W  = MLP_DATA_W,
    parameter int ACC_W   = MLP_ACC_W,
    parameter int FRAC    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic [ADDR_W-1:0]        in_base,
    input  logic [ADDR_W-1:0]        out_base,
    input  logic [ADDR_W-1:0]        in_count,
    input  logic [ADDR_W-1:0]        out_count,
    input  logic [WADDR_W-1:0]       w_base,
    input  logic signed [DATA_W-1:0] neuron_val,
    input  logic signed [DATA_W-1:0] weight,
    output logic [ADDR_W-1:0]        input_addr,
    output logic [WADDR_W-1:0]       weight_addr,
    output logic [ADDR_W-1:0]        output_addr,
    output logic signed [DATA_W-1:0] data,
    output logic                     write_enable,
    output logic                     busy,
    output logic                     done
);

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]  elem;
    logic [ADDR_W-1:0]  row;
    logic [ADDR_W-1:0]  in_base_q;
    logic [ADDR_W-1:0]  out_base_q;
    logic [ADDR_W-1:0]  in_count_q;
    logic [ADDR_W-1:0]  out_count_q;
    logic [WADDR_W-1:0] w_row;
    logic               relu_q;
    logic               rd_valid;

    logic               accept;
    logic               step_elem;
    logic               enter_write;
    logic               next_row;
    logic               mac_clear;
    logic               last_elem;
    logic               last_row;
    logic               busy_next;

    logic signed [DATA_W-1:0] mac_result;

    assign last_elem = (elem + ADDR_W'(1)) == in_count_q;
    assign last_row  = (row + ADDR_W'(1)) == out_count_q;
    assign busy_next = (state_next == ST_READ) || (state_next == ST_DRAIN) || (state_next == ST_WRITE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        step_elem   = 1'b0;
        enter_write = 1'b0;
        next_row    = 1'b0;
        mac_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (out_count == '0) begin
                        state_next = ST_DONE;
                    end else if (in_count == '0) begin
                        state_next = ST_DRAIN;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (last_elem) begin
                    state_next = ST_DRAIN;
                end else begin
                    step_elem = 1'b1;
                end
            end
            ST_DRAIN: begin
                enter_write = 1'b1;
                state_next  = ST_WRITE;
            end
            ST_WRITE: begin
                mac_clear = 1'b1;
                if (last_row) begin
                    state_next = ST_DONE;
                end else begin
                    next_row   = 1'b1;
                    state_next = (in_count_q == '0) ? ST_DRAIN : ST_READ;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Configuration latch, address counters and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            elem         <= '0;
            row          <= '0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            in_count_q   <= '0;
            out_count_q  <= '0;
            w_row        <= '0;
            relu_q       <= 1'b0;
            rd_valid     <= 1'b0;
            input_addr   <= '0;
            weight_addr  <= '0;
            output_addr  <= '0;
            data         <= '0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rd_valid     <= (state == ST_READ);
            write_enable <= enter_write;
            busy         <= busy_next;
            done         <= (state_next == ST_DONE);
            if (accept) begin
                in_base_q   <= in_base;
                out_base_q  <= out_base;
                in_count_q  <= in_count;
                out_count_q <= out_count;
                relu_q      <= relu_en;
                w_row       <= w_base;
                elem        <= '0;
                row         <= '0;
                input_addr  <= in_base;
                weight_addr <= w_base;
            end
            if (step_elem) begin
                elem        <= elem + ADDR_W'(1);
                input_addr  <= input_addr + ADDR_W'(1);
                weight_addr <= weight_addr + WADDR_W'(1);
            end
            if (enter_write) begin
                output_addr <= out_base_q + row;
                data        <= mac_result;
            end
            if (next_row) begin
                row         <= row + ADDR_W'(1);
                elem        <= '0;
                input_addr  <= in_base_q;
                weight_addr <= w_row + WADDR_W'(in_count_q);
                w_row       <= w_row + WADDR_W'(in_count_q);
            end
        end
    end

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .FRAC   (FRAC)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (mac_clear),
        .acc_en  (rd_valid),
        .relu_en (relu_q),
        .a       (neuron_val),
        .b       (weight),
        .result  (mac_result)
    );

endmodule

// File: tb/tb_mlp_layer_engine.sv
// tb/tb_mlp_layer_engine.sv - directed table-driven bench for mlp_layer_engine
module tb_mlp_layer_engine;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               relu_en;
    logic [11:0]        in_base;
    logic [11:0]        out_base;
    logic [11:0]        in_count;
    logic [11:0]        out_count;
    logic [15:0]        w_base;
    logic signed [15:0] neuron_val;
    logic signed [15:0] weight;
    logic [11:0]        input_addr;
    logic [15:0]        weight_addr;
    logic [11:0]        output_addr;
    logic signed [15:0] data;
    logic               write_enable;
    logic               busy;
    logic               done;

    logic signed [15:0] nmem [0:4095];
    logic signed [15:0] wmem [0:65535];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int busy_n;
    int done_n;
    int done_cyc;
    int wa[$];
    int wd[$];
    int wc[$];

    typedef struct {
        bit relu;
        int in_base;
        int in_count;
        int out_base;
        int out_count;
        int w_base;
        int e0;
        int e1;
        int e2;
    } vec_t;

    vec_t vt[7];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        neuron_val <= nmem[input_addr];
        weight     <= wmem[weight_addr];
    end

    mlp_layer_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .relu_en      (relu_en),
        .in_base      (in_base),
        .out_base     (out_base),
        .in_count     (in_count),
        .out_count    (out_count),
        .w_base       (w_base),
        .neuron_val   (neuron_val),
        .weight       (weight),
        .input_addr   (input_addr),
        .weight_addr  (weight_addr),
        .output_addr  (output_addr),
        .data         (data),
        .write_enable (write_enable),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int exp_at(input vec_t v, input int k);
        if (k == 0) return v.e0;
        if (k == 1) return v.e1;
        return v.e2;
    endfunction

    task automatic clear_stats();
        busy_n   = 0;
        done_n   = 0;
        done_cyc = -1;
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    // One observed cycle, sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (busy) busy_n++;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (write_enable) begin
            wa.push_back(int'(output_addr));
            wd.push_back(int'(data));
            wc.push_back(cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_we"}, int'(write_enable), 0);
        check({tag, "_in_addr"}, int'(input_addr), 0);
        check({tag, "_w_addr"}, int'(weight_addr), 0);
        check({tag, "_out_addr"}, int'(output_addr), 0);
        check({tag, "_data"}, int'(data), 0);
    endtask

    task automatic apply_cfg(input vec_t v);
        relu_en   = v.relu;
        in_base   = 12'(v.in_base);
        in_count  = 12'(v.in_count);
        out_base  = 12'(v.out_base);
        out_count = 12'(v.out_count);
        w_base    = 16'(v.w_base);
    endtask

    task automatic run_vec(input vec_t v, input bit disturb, input int id);
        int  e0;
        int  rowlen;
        bit  got;
        int  nw;
        @(negedge clk);
        apply_cfg(v);
        clear_stats();
        start = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        got   = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            tick();
            if (disturb && cyc == e0 + 3) begin
                start     = 1'b1;
                relu_en   = ~v.relu;
                in_base   = 12'd2;
                in_count  = 12'd1;
                out_count = 12'd5;
                out_base  = 12'd50;
                w_base    = 16'd9;
            end
            if (disturb && cyc == e0 + 4) start = 1'b0;
            if (done_n > 0) got = 1'b1;
        end
        check($sformatf("v%0d_timeout", id), int'(got), 1);
        repeat (3) tick();
        rowlen = v.in_count + 2;
        check($sformatf("v%0d_done_pulses", id), done_n, 1);
        check($sformatf("v%0d_busy_cycles", id), busy_n, v.out_count * rowlen);
        check($sformatf("v%0d_done_cycle", id), done_cyc, e0 + v.out_count * rowlen);
        check($sformatf("v%0d_num_writes", id), wa.size(), v.out_count);
        nw = (wa.size() < v.out_count) ? wa.size() : v.out_count;
        for (int k = 0; k < nw; k++) begin
            check($sformatf("v%0d_w%0d_addr", id, k), wa[k], v.out_base + k);
            check($sformatf("v%0d_w%0d_data", id, k), wd[k], exp_at(v, k));
            check($sformatf("v%0d_w%0d_cycle", id, k), wc[k], e0 + k * rowlen + v.in_count + 1);
        end
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 4096; i++) nmem[i] = '0;
        for (int i = 0; i < 256; i++) wmem[i] = '0;
        nmem[0] = 16'sd7;
        nmem[1] = 16'sd3;
        nmem[2] = -16'sd8;
        nmem[3] = 16'sd5;
        wmem[0] = 16'sd1;  wmem[1] = 16'sd2;  wmem[2] = 16'sd1;  wmem[3] = 16'sd1;
        wmem[4] = 16'sd1;  wmem[5] = 16'sd1;  wmem[6] = 16'sd2;  wmem[7] = 16'sd0;
        wmem[8]  = 16'sd32767;  wmem[9]  = 16'sd32767;  wmem[10] = 16'sd0; wmem[11] = 16'sd0;
        wmem[12] = -16'sd32768; wmem[13] = -16'sd32768; wmem[14] = 16'sd0; wmem[15] = 16'sd0;

        //          relu ib ic  ob  oc wb  e0      e1      e2
        vt[0] = '{1'b0, 0, 4, 16, 2, 0, 10,     -6,     0};
        vt[1] = '{1'b1, 0, 4, 16, 2, 0, 10,     0,      0};
        vt[2] = '{1'b0, 0, 4, 20, 2, 8, 32767,  -32768, 0};
        vt[3] = '{1'b1, 0, 4, 20, 2, 8, 32767,  0,      0};
        vt[4] = '{1'b0, 0, 0, 30, 3, 0, 0,      0,      0};
        vt[5] = '{1'b0, 0, 4, 40, 0, 0, 0,      0,      0};
        vt[6] = '{1'b0, 1, 2, 24, 2, 0, -13,    -5,     0};

        reset = 1'b1;
        start = 1'b0;
        apply_cfg(vt[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        for (int v = 0; v < 7; v++) run_vec(vt[v], 1'b0, v);

        // Reset in the middle of row 1 aborts the layer.
        @(negedge clk);
        apply_cfg(vt[0]);
        clear_stats();
        start = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        for (int t = 0; t < 50 && cyc < e0 + 7; t++) tick();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        reset = 1'b0;
        repeat (20) tick();
        check("midreset_writes", wa.size(), 1);
        check("midreset_done", done_n, 0);
        if (wa.size() > 0) check("midreset_w0_addr", wa[0], 16);

        run_vec(vt[0], 1'b0, 7);
        run_vec(vt[1], 1'b1, 8);
        run_vec(vt[2], 1'b1, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
